// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings, Baud_Set codes and the
// oversampling tick divisor helper used by both the transmitter and receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int unsigned OVERSAMPLE = 16;

  // Clocks per oversample tick; unused codes 5-7 fall back to 9600 baud.
  function automatic logic [15:0] baud_tick_div(input int unsigned clk_freq,
                                                input logic [2:0] code);
    int unsigned baud;
    case (code)
      BAUD_19200:  baud = 19200;
      BAUD_38400:  baud = 38400;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      default:     baud = 9600;
    endcase
    return 16'(clk_freq / (baud * OVERSAMPLE));
  endfunction

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick divider plus the 16-phase sample counter that walks
// through each bit period.
module uart_rx_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] tick_div,
  output logic        tick,
  output logic [3:0]  samp_cnt
);

  logic [15:0] tick_cnt;
  logic [15:0] tick_last;

  assign tick_last = tick_div - 16'd1;
  assign tick      = en && (tick_cnt == tick_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      samp_cnt <= samp_cnt + 4'd1;
    end else if (en) begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx resynchroniser, start detect, 16x oversampling with
// 3-sample majority vote, byte assembly and done / framing-error strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] Baud_Set,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  // state | meaning
  // IDLE  | line idle, waiting for a falling edge on rx_s
  // START | validating the start bit; a high decision is a false start
  // DATA  | sampling 8 data bits, LSB first
  // STOP  | mid-bit stop decision: good byte or framing error
  // BREAK | after a framing error, waiting for the line to return high

  localparam logic [15:0] DIV_9600   = baud_tick_div(CLK_FREQ, BAUD_9600);
  localparam logic [15:0] DIV_19200  = baud_tick_div(CLK_FREQ, BAUD_19200);
  localparam logic [15:0] DIV_38400  = baud_tick_div(CLK_FREQ, BAUD_38400);
  localparam logic [15:0] DIV_57600  = baud_tick_div(CLK_FREQ, BAUD_57600);
  localparam logic [15:0] DIV_115200 = baud_tick_div(CLK_FREQ, BAUD_115200);

  uart_state_t state, state_nxt;

  logic        rx_meta, rx_s, rx_s_d;
  logic        start_edge;
  logic [2:0]  baud_q;
  logic [15:0] tick_div;
  logic        tick;
  logic [3:0]  samp_cnt;
  logic        tg_clr, tg_en;
  logic        samp_mid, samp_end;
  logic [2:0]  vote;
  logic        decision;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt;

  logic latch_baud, shift_en, bit_inc, load_data, set_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign start_edge = rx_s_d & ~rx_s;

  always_comb begin
    case (baud_q)
      BAUD_19200:  tick_div = DIV_19200;
      BAUD_38400:  tick_div = DIV_38400;
      BAUD_57600:  tick_div = DIV_57600;
      BAUD_115200: tick_div = DIV_115200;
      default:     tick_div = DIV_9600;
    endcase
  end

  assign tg_clr = (state == ST_IDLE) || (state == ST_BREAK);
  assign tg_en  = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

  uart_rx_tick_gen u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tg_clr),
    .en       (tg_en),
    .tick_div (tick_div),
    .tick     (tick),
    .samp_cnt (samp_cnt)
  );

  assign samp_mid = tick && (samp_cnt == 4'd8);
  assign samp_end = tick && (samp_cnt == 4'd15);

  // The third vote is taken on the decision tick itself, so use rx_s directly.
  assign decision = majority3({rx_s, vote[1], vote[0]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch_baud = 1'b0;
    shift_en   = 1'b0;
    bit_inc    = 1'b0;
    load_data  = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          latch_baud = 1'b1;
          state_nxt  = ST_START;
        end
      end
      ST_START: begin
        if (samp_mid && decision) state_nxt = ST_IDLE;
        else if (samp_end)        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        shift_en = samp_mid;
        if (samp_end) begin
          bit_inc = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (samp_mid) begin
          if (decision) begin
            load_data = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            set_err   = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q    <= BAUD_9600;
      vote      <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      data      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= load_data;
      frame_err <= set_err;
      if (latch_baud) baud_q <= Baud_Set;
      if (tick) begin
        case (samp_cnt)
          4'd6:    vote[0] <= rx_s;
          4'd7:    vote[1] <= rx_s;
          4'd8:    vote[2] <= rx_s;
          default: ;
        endcase
      end
      if (shift_en) shift_reg <= {decision, shift_reg[7:1]};
      if (state == ST_IDLE) bit_cnt <= '0;
      else if (bit_inc)     bit_cnt <= bit_cnt + 3'd1;
      if (load_data) data <= shift_reg;
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of frames across all baud codes plus
// hand-written glitch, framing, back-to-back, baud-change and reset sequences.
module tb_uart_rx;
  import uart_rx_pkg::*;

  // Low clock keeps 9600-baud frames short: divisors 24, 12, 6, 4, 2.
  localparam int CLK_FREQ = 3686400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] Baud_Set;
  logic       rx;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Baud_Set  (Baud_Set),
    .rx        (rx),
    .data      (data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
  int last_done_cyc = 0;
  int start_cyc = 0;
  logic prev_done = 1'b0;
  logic [7:0] data_hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      data_hist.push_back(data);
    end
    if (frame_err) err_cnt++;
    if (rx_done && frame_err) both_cnt++;
    if (rx_done && prev_done) wide_cnt++;
    prev_done = rx_done;
  end

  typedef struct {
    logic [2:0] baud;
    logic [7:0] din;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[8];

  function automatic int div_of(input int code);
    case (code)
      1: return 12;
      2: return 6;
      3: return 4;
      4: return 2;
      default: return 24;
    endcase
  endfunction

  function automatic int exp_div100(input int code);
    case (code)
      0: return 651;
      1: return 325;
      2: return 162;
      3: return 108;
      default: return 54;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame with the bit period of `code`; the stop bit lasts
  // stop16/16 of a bit. Optionally changes Baud_Set or pulses reset mid-bit.
  task automatic send_frame(input int code, input logic [7:0] b, input logic stop_val,
                            input int stop16, input int chg_bit, input logic [2:0] chg_code,
                            input int rst_bit);
    int d;
    logic [9:0] fr;
    d  = div_of(code);
    fr = {stop_val, b, 1'b0};
    @(posedge clk);
    #1;
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      int len;
      len = (i == 9) ? stop16 * d : 16 * d;
      rx = fr[i];
      for (int c = 0; c < len; c++) begin
        if (c == len / 2 && i == chg_bit) Baud_Set = chg_code;
        if (c == len / 2 && i == rst_bit) begin
          rx    = 1'b1;
          rst_n = 1'b0;
          #2;
          chk("rst_mid_data", data, 8'h00);
          chk("rst_mid_done", rx_done, 1'b0);
          chk("rst_mid_err", frame_err, 1'b0);
          chk("rst_mid_busy", rx_busy, 1'b0);
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          return;
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int d0, e0, d;

    vecs[0] = '{3'd4, 8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{3'd0, 8'h00, 1'b1, 8'h00, 1, 0};
    vecs[2] = '{3'd1, 8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[3] = '{3'd3, 8'h01, 1'b1, 8'h01, 1, 0};
    vecs[4] = '{3'd2, 8'h80, 1'b1, 8'h80, 1, 0};
    vecs[5] = '{3'd5, 8'h5A, 1'b1, 8'h5A, 1, 0};
    vecs[6] = '{3'd3, 8'hC3, 1'b0, 8'h5A, 0, 1};
    vecs[7] = '{3'd7, 8'h96, 1'b1, 8'h96, 1, 0};

    rst_n    = 1'b0;
    rx       = 1'b1;
    Baud_Set = 3'd4;
    #12;
    chk("reset_data", data, 8'h00);
    chk("reset_done", rx_done, 1'b0);
    chk("reset_err", frame_err, 1'b0);
    chk("reset_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    wait_cyc(5);

    for (int c = 0; c < 5; c++)
      chk($sformatf("tick_div_100M_code%0d", c), 32'(baud_tick_div(100000000, 3'(c))),
          32'(exp_div100(c)));

    for (int i = 0; i < 8; i++) begin
      Baud_Set = vecs[i].baud;
      d  = div_of(int'(vecs[i].baud));
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(int'(vecs[i].baud), vecs[i].din, vecs[i].stop, 16, -1, 3'd0, -1);
      rx = 1'b1;
      wait_cyc(4 * d + 8);
      chk($sformatf("v%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      if (vecs[i].exp_done == 1)
        chk_range($sformatf("v%0d_latency", i), last_done_cyc - start_cyc,
                  152 * d + 2, 153 * d + 4);
    end

    // Short low pulse at 9600 (bit = 384 clk): all three votes see high.
    Baud_Set = 3'd0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge clk);
    #1;
    rx = 1'b0;
    wait_cyc(10);
    chk("glitch_busy_rise", rx_busy, 1'b1);
    wait_cyc(30);
    rx = 1'b1;
    wait_cyc(160);
    chk("glitch_busy_before_decision", rx_busy, 1'b1);
    wait_cyc(40);
    chk("glitch_busy_after_decision", rx_busy, 1'b0);
    wait_cyc(400);
    chk("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    chk("glitch_no_err", 32'(err_cnt - e0), 32'd0);

    // Framing error: stop low, line held low for 3 bit periods in total.
    Baud_Set = 3'd4;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(4, 8'h3C, 1'b0, 16, -1, 3'd0, -1);
    wait_cyc(2 * 16 * 2);
    chk("ferr_busy_held", rx_busy, 1'b1);
    chk("ferr_count", 32'(err_cnt - e0), 32'd1);
    chk("ferr_no_done", 32'(done_cnt - d0), 32'd0);
    chk("ferr_data_kept", data, 8'h96);
    rx = 1'b1;
    wait_cyc(6);
    chk("ferr_busy_release", rx_busy, 1'b0);
    wait_cyc(20);

    // Back-to-back with a shortened stop bit.
    d0 = done_cnt;
    send_frame(4, 8'h00, 1'b1, 15, -1, 3'd0, -1);
    send_frame(4, 8'hFF, 1'b1, 16, -1, 3'd0, -1);
    wait_cyc(20);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    if (data_hist.size() >= 2) begin
      chk("b2b_first", data_hist[data_hist.size() - 2], 8'h00);
      chk("b2b_second", data_hist[data_hist.size() - 1], 8'hFF);
    end else begin
      chk("b2b_history", 32'(data_hist.size()), 32'd2);
    end

    // Baud_Set changes during data bit 3 (frame bit index 4).
    Baud_Set = 3'd2;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(2, 8'h5A, 1'b1, 16, 4, 3'd0, -1);
    wait_cyc(40);
    chk("bchg_done", 32'(done_cnt - d0), 32'd1);
    chk("bchg_data", data, 8'h5A);
    d0 = done_cnt;
    send_frame(0, 8'h3A, 1'b1, 16, -1, 3'd0, -1);
    wait_cyc(120);
    chk("bchg_next_done", 32'(done_cnt - d0), 32'd1);
    chk("bchg_next_data", data, 8'h3A);
    chk("bchg_err", 32'(err_cnt - e0), 32'd0);

    // Reset during data bit 4 (frame bit index 5).
    Baud_Set = 3'd4;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(4, 8'h99, 1'b1, 16, -1, 3'd0, 5);
    wait_cyc(400);
    chk("rst_abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_abort_busy", rx_busy, 1'b0);
    send_frame(4, 8'h81, 1'b1, 16, -1, 3'd0, -1);
    wait_cyc(20);
    chk("rst_next_done", 32'(done_cnt - d0), 32'd1);
    chk("rst_next_data", data, 8'h81);
    chk("rst_next_err", 32'(err_cnt - e0), 32'd0);

    chk("done_err_overlap", 32'(both_cnt), 32'd0);
    chk("done_pulse_width", 32'(wide_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
